// File: rtl/dnn_out_argmax.sv
// rtl/dnn_out_argmax.sv - capture engine scores, scan sequentially for argmax/max/tie, indexed readout
module dnn_out_argmax #(
  parameter int DATA_WIDTH = 4,
  parameter int N_CLASSES  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [N_CLASSES*DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]            rd_idx,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            busy,
  output logic                            result_valid,
  output logic [IDX_WIDTH-1:0]            result_class,
  output logic [DATA_WIDTH-1:0]           result_max,
  output logic                            result_tie,
  output logic                            overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N_CLASSES - 1);

  logic [1:0]                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] buf_q [N_CLASSES];
  logic signed [DATA_WIDTH-1:0] buf_d [N_CLASSES];
  logic [IDX_WIDTH-1:0]         cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]         run_class_q, run_class_d;
  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic                         run_tie_q, run_tie_d;
  logic [IDX_WIDTH-1:0]         res_class_q, res_class_d;
  logic signed [DATA_WIDTH-1:0] res_max_q, res_max_d;
  logic                         res_tie_q, res_tie_d;
  logic                         res_valid_q, res_valid_d;
  logic                         overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic signed [DATA_WIDTH-1:0] cur;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    run_class_d = run_class_q;
    run_max_d   = run_max_q;
    run_tie_d   = run_tie_q;
    res_class_d = res_class_q;
    res_max_d   = res_max_q;
    res_tie_d   = res_tie_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    cur         = buf_q[cnt_q];
    rd_data_d   = (int'(rd_idx) < N_CLASSES) ? buf_q[rd_idx] : buf_q[0];

    case (state_q)
      SCAN: begin
        if (in_valid) overrun_d = 1'b1;
        // Strict greater keeps the lowest index among equal maxima.
        if (cur > run_max_q) begin
          run_max_d   = cur;
          run_class_d = cnt_q;
          run_tie_d   = 1'b0;
        end else if (cur == run_max_q) begin
          run_tie_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        res_class_d = run_class_q;
        res_max_d   = run_max_q;
        res_tie_d   = run_tie_q;
        res_valid_d = 1'b1;
      end
      default: ;
    endcase

    if (in_valid && state_q != SCAN) begin
      for (int k = 0; k < N_CLASSES; k++) buf_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      run_max_d   = in_data[DATA_WIDTH-1:0];
      run_class_d = '0;
      run_tie_d   = 1'b0;
      cnt_d       = IDX_WIDTH'(1);
      res_valid_d = 1'b0;
      state_d     = SCAN;
    end

    if (clear) begin
      for (int k = 0; k < N_CLASSES; k++) buf_d[k] = '0;
      state_d     = IDLE;
      cnt_d       = '0;
      run_class_d = '0;
      run_max_d   = '0;
      run_tie_d   = 1'b0;
      res_class_d = '0;
      res_max_d   = '0;
      res_tie_d   = 1'b0;
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
      rd_data_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int k = 0; k < N_CLASSES; k++) buf_q[k] <= '0;
      cnt_q       <= '0;
      run_class_q <= '0;
      run_max_q   <= '0;
      run_tie_q   <= 1'b0;
      res_class_q <= '0;
      res_max_q   <= '0;
      res_tie_q   <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      run_class_q <= run_class_d;
      run_max_q   <= run_max_d;
      run_tie_q   <= run_tie_d;
      res_class_q <= res_class_d;
      res_max_q   <= res_max_d;
      res_tie_q   <= res_tie_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign result_valid = res_valid_q;
  assign result_class = res_class_q;
  assign result_max   = res_max_q;
  assign result_tie   = res_tie_q;
  assign overrun      = overrun_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_dnn_out_argmax.sv
// tb/tb_dnn_out_argmax.sv - randomized scoreboard bench for dnn_out_argmax (10x4 and 16x8 instances)
module tb_dnn_out_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear;
  logic        in_valid;
  logic [39:0] in_data;
  logic [3:0]  rd_idx, rd_data, result_class, result_max;
  logic        busy, result_valid, result_tie, overrun;

  logic         in_valid_b;
  logic [127:0] in_data_b;
  logic [3:0]   rd_idx_b, result_class_b;
  logic [7:0]   rd_data_b, result_max_b;
  logic         busy_b, result_valid_b, result_tie_b, overrun_b;

  dnn_out_argmax #(.DATA_WIDTH(4), .N_CLASSES(10), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .result_valid(result_valid),
    .result_class(result_class), .result_max(result_max), .result_tie(result_tie),
    .overrun(overrun));

  dnn_out_argmax #(.DATA_WIDTH(8), .N_CLASSES(16), .IDX_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid_b), .in_data(in_data_b),
    .rd_idx(rd_idx_b), .rd_data(rd_data_b), .busy(busy_b), .result_valid(result_valid_b),
    .result_class(result_class_b), .result_max(result_max_b), .result_tie(result_tie_b),
    .overrun(overrun_b));

  typedef struct { int cls; int mx; bit tie; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;
  int buf_a[16];
  int buf_b[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Argmax reference: largest value, first index holding it, tie if it occurs more than once.
  function automatic exp_t model(input int s[16], input int n);
    exp_t e;
    int   cnt;
    e.mx = s[0];
    e.cls = 0;
    for (int i = 0; i < n; i++) if (s[i] > e.mx) begin e.mx = s[i]; e.cls = i; end
    cnt = 0;
    for (int i = 0; i < n; i++) if (s[i] == e.mx) cnt++;
    e.tie = (cnt > 1);
    return e;
  endfunction

  function automatic logic [39:0] pack_a(input int s[16]);
    logic [39:0] p;
    for (int k = 0; k < 10; k++) p[k*4 +: 4] = 4'(s[k]);
    return p;
  endfunction

  function automatic logic [127:0] pack_b(input int s[16]);
    logic [127:0] p;
    for (int k = 0; k < 16; k++) p[k*8 +: 8] = 8'(s[k]);
    return p;
  endfunction

  logic rv_a_prev = 1'b0;
  logic rv_b_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (result_valid && !rv_a_prev) begin
      if (q_a.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_class", int'(result_class), e.cls);
        chk("a_max", sx4(result_max), e.mx);
        chk("a_tie", int'(result_tie), int'(e.tie));
      end
    end
    rv_a_prev = result_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (result_valid_b && !rv_b_prev) begin
      if (q_b.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_class", int'(result_class_b), e.cls);
        chk("b_max", sx8(result_max_b), e.mx);
        chk("b_tie", int'(result_tie_b), int'(e.tie));
      end
    end
    rv_b_prev = result_valid_b;
  end

  task automatic cap_a(input int s[16], output int lat, output int bz);
    @(negedge clk);
    in_data = pack_a(s);
    in_valid = 1'b1;
    q_a.push_back(model(s, 10));
    for (int k = 0; k < 16; k++) buf_a[k] = (k < 10) ? s[k] : 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    bz = 0;
    while (!result_valid && lat < 40) begin
      if (busy) bz++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic cap_b(input int s[16], output int lat, output int bz);
    @(negedge clk);
    in_data_b = pack_b(s);
    in_valid_b = 1'b1;
    q_b.push_back(model(s, 16));
    for (int k = 0; k < 16; k++) buf_b[k] = s[k];
    @(negedge clk);
    in_valid_b = 1'b0;
    lat = 0;
    bz = 0;
    while (!result_valid_b && lat < 60) begin
      if (busy_b) bz++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rd_check_a(input int k);
    @(negedge clk);
    rd_idx = 4'(k);
    @(negedge clk);
    chk($sformatf("a_rd_idx%0d", k), sx4(rd_data), (k < 10) ? buf_a[k] : buf_a[0]);
  endtask

  int sc[16];
  int v2[16];
  int lat, bz, n;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; rd_idx = '0;
    in_valid_b = 1'b0; in_data_b = '0; rd_idx_b = '0;
    for (int k = 0; k < 16; k++) begin buf_a[k] = 0; buf_b[k] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_class", int'(result_class), 0);
    chk("rst_result_max", int'(result_max), 0);
    chk("rst_result_tie", int'(result_tie), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_b_result_valid", int'(result_valid_b), 0);
    rst = 1'b0;
    rd_check_a(3);

    sc = '{0, 1, 2, -3, 7, 1, 0, -8, 3, 2, 0, 0, 0, 0, 0, 0};
    cap_a(sc, lat, bz);
    chk("d1_latency", lat, 10);
    chk("d1_busy_cycles", bz, 9);
    chk("d1_class_const", int'(result_class), 4);
    chk("d1_max_const", sx4(result_max), 7);
    for (int k = 0; k < 16; k++) rd_check_a(k);

    for (int k = 0; k < 16; k++) sc[k] = -8;
    cap_a(sc, lat, bz);
    chk("all_neg8_tie_const", int'(result_tie), 1);
    for (int k = 0; k < 16; k++) sc[k] = 0;
    sc[3] = 5; sc[6] = 5;
    cap_a(sc, lat, bz);
    chk("dup5_class_const", int'(result_class), 3);

    // Second strobe mid-scan is dropped and flags overrun.
    sc = '{1, -2, 3, 6, 0, 5, -1, 2, 4, -7, 0, 0, 0, 0, 0, 0};
    v2 = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    in_data = pack_a(sc); in_valid = 1'b1;
    q_a.push_back(model(sc, 10));
    for (int k = 0; k < 16; k++) buf_a[k] = (k < 10) ? sc[k] : 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    in_data = pack_a(v2); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    n = 0;
    while (!result_valid && n < 40) begin @(negedge clk); n++; end
    chk("ovr_first_done", int'(result_valid), 1);
    rd_check_a(4);
    sc = '{-1, -1, -5, 2, 0, -3, 2, 1, 0, -8, 0, 0, 0, 0, 0, 0};
    cap_a(sc, lat, bz);
    chk("ovr_third_latency", lat, 10);
    chk("ovr_sticky", int'(overrun), 1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int k = 0; k < 16; k++) buf_a[k] = 0;
    chk("clr_overrun", int'(overrun), 0);
    chk("clr_result_valid", int'(result_valid), 0);

    // clear beats a simultaneous strobe.
    sc = '{3, 3, 3, 3, 7, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = pack_a(sc);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clrcap_busy", int'(busy), 0);
    chk("clrcap_result_valid", int'(result_valid), 0);
    rd_check_a(4);

    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 16; k++) sc[k] = (k < 10) ? int'($urandom_range(0, 15)) - 8 : 0;
      if ($urandom_range(0, 2) == 0) sc[$urandom_range(1, 9)] = sc[$urandom_range(0, 9)];
      cap_a(sc, lat, bz);
      chk("rand_latency", lat, 10);
      rd_check_a(int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset between edges mid-scan.
    sc = '{2, 4, 6, -1, 0, 1, 5, 3, -4, 6, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    in_data = pack_a(sc); in_valid = 1'b1;
    for (int k = 0; k < 16; k++) buf_a[k] = (k < 10) ? sc[k] : 0;
    @(negedge clk);
    in_valid = 1'b0;
    rd_idx = 4'd1;
    repeat (2) @(negedge clk);
    chk("arst_pre_busy", int'(busy), 1);
    chk("arst_pre_rd", sx4(rd_data), buf_a[1]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_result_valid", int'(result_valid), 0);
    chk("arst_result_class", int'(result_class), 0);
    chk("arst_result_max", int'(result_max), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) buf_a[k] = 0;
    repeat (12) @(negedge clk);
    chk("arst_no_result", int'(result_valid), 0);

    for (int k = 1; k < 15; k++) sc[k] = int'($urandom_range(0, 254)) - 128;
    sc[0] = -128; sc[15] = 127;
    cap_b(sc, lat, bz);
    chk("b_latency", lat, 16);
    chk("b_busy_cycles", bz, 15);
    chk("b_class_const", int'(result_class_b), 15);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) sc[k] = int'($urandom_range(0, 7)) - 4;
      cap_b(sc, lat, bz);
      chk("b_rand_latency", lat, 16);
    end
    @(negedge clk); rd_idx_b = 4'd9;
    @(negedge clk);
    chk("b_rd_idx9", sx8(rd_data_b), buf_b[9]);

    repeat (2) @(negedge clk);
    chk("a_scoreboard_empty", q_a.size(), 0);
    chk("b_scoreboard_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dnn_out_argmax.md
Name: dnn_out_argmax

Overview:
Result-capture and classification stage placed after the inference engine (e.g. dnn_sigmoid_fix4 and its wider successors). On a capture pulse it latches the engine's N_CLASSES-wide output vector into an internal buffer. It then scans the buffer sequentially to produce the winning class index, the winning score and a tie flag. It also provides registered indexed readout of any latched score, generalising the fixed 10-way, 4-bit combinational output selector.

Parameters:
DATA_WIDTH, 4, width of one signed score.
N_CLASSES, 10, number of output neurons; legal range 2..256.
IDX_WIDTH, 4, index width; must satisfy 2**IDX_WIDTH >= N_CLASSES.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous soft clear; same effect as rst, applied on the clock edge.
in_valid  input  1  one-cycle capture strobe; connect to the engine's done pulse.
in_data  input  N_CLASSES*DATA_WIDTH  packed signed scores; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
rd_idx  input  IDX_WIDTH  readout index into the latched buffer.
rd_data  output  DATA_WIDTH  signed latched score for rd_idx; registered.
busy  output  1  high while a scan is in progress.
result_valid  output  1  high while result_* holds the classification of the most recent capture.
result_class  output  IDX_WIDTH  argmax index.
result_max  output  DATA_WIDTH  signed maximum score.
result_tie  output  1  high if another class equals result_max.
overrun  output  1  sticky; set when in_valid arrives while busy.

Behaviour:
- Reset (rst async, or clear sync): FSM goes to IDLE. All outputs are 0. The buffer, scan counter and overrun flag are zeroed.
- FSM states: IDLE, SCAN, DONE.
- IDLE or DONE with in_valid=1:
  - latch all of in_data into the buffer
  - set the running max to score[0], the running class to 0 and the running tie to 0
  - set the scan counter to 1
  - go to SCAN
  - on the next cycle: busy=1 and result_valid=0
- SCAN: one compare per cycle on score[cnt] versus the running max, using a signed comparison.
  - greater: update max and class; clear tie.
  - equal: keep the lower index; set tie.
  - less: no change.
  - Increment cnt. After comparing index N_CLASSES-1, go to DONE.
- DONE:
  - result_class, result_max and result_tie are registered from the running values.
  - result_valid=1 and busy=0.
  - Outputs hold until the next capture or reset.
- Latency: with in_valid sampled at edge 0, result_valid first reads 1 after edge N_CLASSES (10 cycles at default). Throughput is one capture per N_CLASSES+1 cycles.
- in_valid while in SCAN: the capture is dropped, the buffer is not modified, the scan continues, and overrun is set to 1. overrun stays set until rst or clear.
- in_valid in the same cycle as clear: clear wins and nothing is captured.
- rd_data:
  - registered from the buffer with 1-cycle latency (rd_data at edge n+1 reflects rd_idx at edge n)
  - valid in every state; it reflects the buffer as currently latched, including during SCAN
  - when rd_idx >= N_CLASSES, rd_data returns score[0]
- result_max sign-extension and the comparison use full DATA_WIDTH signed arithmetic with no saturation.
- rst asserted mid-SCAN aborts immediately. The partial result is discarded and result_valid stays 0.
- Before the first capture the buffer is zero, so rd_data returns 0.

Test Plan:
- Reset, then capture in_valid with scores {0,1,2,-3,7,1,0,-8,3,2} (class 0..9) -> busy high for 9 cycles; result_valid rises 10 cycles after the strobe; result_class=4, result_max=7, result_tie=0.
- Capture all scores=-8 -> result_class=0, result_max=-8, result_tie=1. Then capture {...,class3=5,class6=5, rest 0} -> result_class=3, result_tie=1.
- Second in_valid 4 cycles after the first -> overrun=1 and the result matches the first vector. A third capture after DONE succeeds and overrun stays 1 until clear.
- After a capture, sweep rd_idx 0..15 -> rd_data equals score[k] one cycle later for k<10 and score[0] for 10..15.
- Assert rst asynchronously (between edges) mid-SCAN -> all outputs 0 immediately. Assert clear with in_valid in the same cycle -> IDLE, no capture, busy=0.
- Rerun with N_CLASSES=16, DATA_WIDTH=8, with the max at index 15 (value 127) and index 0 at -128 -> result_class=15 after 16 cycles.
